// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler
// Walks the 5x5 convolution datapath over every output pixel of a 12x12 image
// after a single CPU start command, collecting the scalar results in an
// internal 8x8 buffer and exposing busy/done/error/progress status.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   en_i, we_i            bus access strobe and direction (1 = write)
//   addr_i, data_i        byte address and write data
//   ready_o, data_o       registered access acknowledge and read data
//   dp_start_o            one-cycle start pulse to the datapath
//   dp_index_o            top-left image index of the pixel being issued
//   dp_abort_o            one-cycle abort pulse to the datapath
//   dp_done_i             datapath result-valid pulse
//   dp_result_i           datapath result (FP32 bits, stored opaque)
//
// Register window (offsets from BASE_ADDR):
//   0x000 CTRL   (wo)  1 = start, 2 = abort
//   0x004 STATUS (ro)  bit0 busy, bit1 done, bit2 error, [22:16] pixels done
//   0x100+4n RESULT[n] (ro)
module conv_tile_scheduler #(
    parameter int               XLEN      = 32,
    parameter int               IMG_W     = 12,
    parameter int               K         = 5,
    parameter logic [XLEN-1:0]  BASE_ADDR = 32'hC450_0000,
    parameter int               TIMEOUT   = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic            ready_o,
    output logic [XLEN-1:0] data_o,
    output logic            dp_start_o,
    output logic [XLEN-1:0] dp_index_o,
    output logic            dp_abort_o,
    input  logic            dp_done_i,
    input  logic [XLEN-1:0] dp_result_i
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int NOUT  = OUT_W * OUT_W;
    localparam int CW    = $clog2(OUT_W);
    localparam int RW    = $clog2(OUT_W + 1);
    localparam int NW    = $clog2(NOUT + 1);
    localparam int IW    = $clog2(NOUT);
    localparam int TW    = $clog2(TIMEOUT);

    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(NOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_r, state_n;
    logic [RW-1:0]   row_r, row_n;
    logic [CW-1:0]   col_r, col_n;
    logic [NW-1:0]   count_r, count_n;
    logic [TW-1:0]   tmo_r, tmo_n;
    logic [XLEN-1:0] res_r, res_n;
    logic            done_r, done_n;
    logic            error_r, error_n;
    logic            abort_n;
    logic            store_s;

    logic            ready_r;
    logic [XLEN-1:0] data_r;
    logic            dp_start_r;
    logic            dp_abort_r;
    logic [XLEN-1:0] dp_index_r;

    logic [XLEN-1:0] mem_r [NOUT];

    logic            win_s;
    logic [8:0]      off_s;
    logic            ctrl_wr_s;
    logic            start_s;
    logic            abort_s;
    logic            busy_s;
    logic [XLEN-1:0] status_s;
    logic [XLEN-1:0] rd_data_s;
    logic [XLEN-1:0] idx_s;

    // The window is 0x200 bytes and BASE_ADDR is 0x200-aligned, so the upper
    // address bits alone decide membership.
    assign win_s     = (addr_i[XLEN-1:9] == BASE_ADDR[XLEN-1:9]);
    assign off_s     = addr_i[8:0];
    assign ctrl_wr_s = en_i & we_i & win_s & (off_s == 9'h000);
    assign start_s   = ctrl_wr_s & (data_i == XLEN'(1));
    assign abort_s   = ctrl_wr_s & (data_i == XLEN'(2));
    assign busy_s    = (state_r != S_IDLE);
    assign idx_s     = XLEN'(row_n) * XLEN'(IMG_W) + XLEN'(col_n);

    assign ready_o    = ready_r;
    assign data_o     = data_r;
    assign dp_start_o = dp_start_r;
    assign dp_abort_o = dp_abort_r;
    assign dp_index_o = dp_index_r;

    // Status word assembly.
    always_comb begin
        status_s           = '0;
        status_s[0]        = busy_s;
        status_s[1]        = done_r;
        status_s[2]        = error_r;
        status_s[16 +: NW] = count_r;
    end

    // Read data multiplexer; unmapped offsets inside the window read as zero.
    always_comb begin
        rd_data_s = '0;
        if (off_s == 9'h004) begin
            rd_data_s = status_s;
        end else if (off_s[8] && (off_s[1:0] == 2'b00)) begin
            rd_data_s = mem_r[off_s[IW+1:2]];
        end else begin
            rd_data_s = '0;
        end
    end

    // Next-state and control logic; an abort in any busy state preempts all.
    always_comb begin
        state_n = state_r;
        row_n   = row_r;
        col_n   = col_r;
        count_n = count_r;
        tmo_n   = tmo_r;
        res_n   = res_r;
        done_n  = done_r;
        error_n = error_r;
        abort_n = 1'b0;
        store_s = 1'b0;
        if (abort_s && busy_s) begin
            state_n = S_IDLE;
            abort_n = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        done_n  = 1'b0;
                        error_n = 1'b0;
                        count_n = '0;
                        row_n   = '0;
                        col_n   = '0;
                        state_n = S_ISSUE;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    tmo_n   = '0;
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (dp_done_i) begin
                        res_n   = dp_result_i;
                        state_n = S_STORE;
                    end else if (tmo_r == TMO_LAST) begin
                        error_n = 1'b1;
                        abort_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        tmo_n = tmo_r + TW'(1);
                    end
                end
                S_STORE: begin
                    store_s = 1'b1;
                    count_n = count_r + NW'(1);
                    if (col_r == COL_LAST) begin
                        col_n = '0;
                        row_n = row_r + RW'(1);
                    end else begin
                        col_n = col_r + CW'(1);
                    end
                    if (count_n == CNT_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
                S_DONE: begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // FSM state and run-control registers, plus the datapath strobes which are
    // registered from the next state so they line up with ISSUE / IDLE entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= S_IDLE;
            row_r      <= '0;
            col_r      <= '0;
            count_r    <= '0;
            tmo_r      <= '0;
            res_r      <= '0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            dp_start_r <= 1'b0;
            dp_abort_r <= 1'b0;
            dp_index_r <= '0;
        end else begin
            state_r    <= state_n;
            row_r      <= row_n;
            col_r      <= col_n;
            count_r    <= count_n;
            tmo_r      <= tmo_n;
            res_r      <= res_n;
            done_r     <= done_n;
            error_r    <= error_n;
            dp_start_r <= (state_n == S_ISSUE);
            dp_abort_r <= abort_n;
            if (state_n == S_ISSUE) begin
                dp_index_r <= idx_s;
            end
        end
    end

    // Bus acknowledge and read data; data_o holds until the next read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_r <= 1'b0;
            data_r  <= '0;
        end else begin
            ready_r <= en_i & win_s;
            if (en_i && win_s && !we_i) begin
                data_r <= rd_data_s;
            end
        end
    end

    // Result buffer, deliberately not reset. Pixels complete in row-major
    // order, so the running count equals row*OUT_W+col at STORE time.
    always_ff @(posedge clk_i) begin
        if (store_s) begin
            mem_r[count_r[IW-1:0]] <= res_r;
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: bus vector table, datapath
// model with selectable latency, scoreboards for issued indices and bus acks.
module tb_conv_tile_scheduler;

    localparam logic [31:0] BASE = 32'hC450_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        dp_start_o;
    logic [31:0] dp_index_o;
    logic        dp_abort_o;
    logic        dp_done_i;
    logic [31:0] dp_result_i;

    conv_tile_scheduler dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .dp_start_o  (dp_start_o),
        .dp_index_o  (dp_index_o),
        .dp_abort_o  (dp_abort_o),
        .dp_done_i   (dp_done_i),
        .dp_result_i (dp_result_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboards.
    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } ack_t;

    logic [31:0] idx_q[$];
    ack_t        ack_q[$];
    ack_t        mon_a;

    int cyc       = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int start_cyc = 0;
    int abort_cyc = 0;

    // Datapath model: returns result = index, 10 cycles after each start.
    int          dp_mode = 0;
    int          dp_cnt  = 0;
    logic [31:0] dp_idx  = 32'd0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            dp_cnt    = 0;
            dp_done_i = 1'b0;
        end else begin
            dp_done_i = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt = dp_cnt - 1;
                if (dp_cnt == 0) begin
                    dp_done_i   = 1'b1;
                    dp_result_i = dp_idx;
                end
            end
            if (dp_start_o && dp_mode == 0) begin
                dp_cnt = 10;
                dp_idx = dp_index_o;
            end
        end
    end

    // Output monitor: pops scoreboards on dp_start_o and ready_o.
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_i) begin
            if (dp_start_o) begin
                start_cnt++;
                start_cyc = cyc;
                if (idx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got index 0x%08h expected no start", dp_index_o);
                end else begin
                    check("dp_index", dp_index_o, idx_q.pop_front());
                end
            end
            if (dp_abort_o) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            if (ready_o) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready=1 expected ready=0");
                end else begin
                    mon_a = ack_q.pop_front();
                    if (mon_a.chk) check(mon_a.name, data_o, mon_a.exp);
                end
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic exp_rdy, input logic chk, input logic [31:0] exp,
                       input string name);
        ack_t a;
        @(negedge clk_i);
        en_i   = 1'b1;
        we_i   = we;
        addr_i = addr;
        data_i = data;
        if (exp_rdy) begin
            a.chk  = chk;
            a.exp  = exp;
            a.name = name;
            ack_q.push_back(a);
        end
        @(negedge clk_i);
        en_i = 1'b0;
        we_i = 1'b0;
        #1;
        if (exp_rdy) begin
            check({name, "_ack_pending"}, 32'(ack_q.size()), 32'd0);
            ack_q.delete();
        end else begin
            check({name, "_noack"}, {31'd0, ready_o}, 32'd0);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input string name);
        bus(1'b1, BASE + off, data, 1'b1, 1'b0, 32'd0, name);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        bus(1'b0, BASE + off, 32'd0, 1'b1, 1'b1, exp, name);
    endtask

    // Poll STATUS until busy clears, bounded.
    task automatic wait_idle(input int max_reads, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_reads && !ok; i++) begin
            bus(1'b0, BASE + 32'h4, 32'd0, 1'b1, 1'b0, 32'd0, "poll");
            if (data_o[0] == 1'b0) ok = 1'b1;
        end
        check({name, "_idle_reached"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_starts(input int target, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && start_cnt < target; i++) @(negedge clk_i);
        check(name, 32'(start_cnt), 32'(target));
    endtask

    task automatic push_run(input int npix);
        for (int p = 0; p < npix; p++) idx_q.push_back(32'((p / 8) * 12 + (p % 8)));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rdy;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[11];
    int   s0;
    int   a0;

    initial begin
        vecs[0]  = '{1'b0, BASE + 32'h004, 32'd0,          1'b1, 32'd0, "status_reset"};
        vecs[1]  = '{1'b0, BASE + 32'h1F0, 32'd0,          1'b1, 32'd0, "unmapped_1f0"};
        vecs[2]  = '{1'b0, BASE + 32'h200, 32'd0,          1'b0, 32'd0, "outside_200"};
        vecs[3]  = '{1'b0, BASE - 32'h004, 32'd0,          1'b0, 32'd0, "outside_below"};
        vecs[4]  = '{1'b1, BASE + 32'h004, 32'hFFFF_FFFF,  1'b1, 32'd0, "wr_status_ro"};
        vecs[5]  = '{1'b1, BASE + 32'h000, 32'd3,          1'b1, 32'd0, "ctrl_noop"};
        vecs[6]  = '{1'b1, BASE + 32'h000, 32'd2,          1'b1, 32'd0, "abort_idle"};
        vecs[7]  = '{1'b0, BASE + 32'h004, 32'd0,          1'b1, 32'd0, "status_idle"};
        vecs[8]  = '{1'b0, BASE + 32'h008, 32'd0,          1'b1, 32'd0, "unmapped_008"};
        vecs[9]  = '{1'b1, BASE + 32'h200, 32'd1,          1'b0, 32'd0, "wr_outside"};
        vecs[10] = '{1'b0, BASE + 32'h004, 32'd0,          1'b1, 32'd0, "status_after_outside"};

        rst_i       = 1'b1;
        en_i        = 1'b0;
        we_i        = 1'b0;
        addr_i      = 32'd0;
        data_i      = 32'd0;
        dp_done_i   = 1'b0;
        dp_result_i = 32'd0;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_ready",    {31'd0, ready_o},    32'd0);
        check("rst_data",     data_o,              32'd0);
        check("rst_dp_start", {31'd0, dp_start_o}, 32'd0);
        check("rst_dp_abort", {31'd0, dp_abort_o}, 32'd0);
        check("rst_dp_index", dp_index_o,          32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Register window vectors while idle.
        for (int i = 0; i < 11; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdy,
                !vecs[i].we, vecs[i].exp, vecs[i].name);
        end
        check("idle_no_starts", 32'(start_cnt), 32'd0);
        check("idle_no_aborts", 32'(abort_cnt), 32'd0);

        // Full 64-pixel run.
        dp_mode = 0;
        push_run(64);
        s0 = start_cnt;
        a0 = abort_cnt;
        wr(32'h0, 32'd1, "start_run1");
        wait_idle(1500, "run1");
        check("run1_starts", 32'(start_cnt - s0), 32'd64);
        check("run1_idx_left", 32'(idx_q.size()), 32'd0);
        check("run1_aborts", 32'(abort_cnt - a0), 32'd0);
        rd(32'h004, 32'h0040_0002, "run1_status");
        rd(32'h1FC, 32'd91, "result63");
        rd(32'h100, 32'd0,  "result0");
        rd(32'h124, 32'd13, "result9");
        rd(32'h11C, 32'd7,  "result7");
        rd(32'h120, 32'd12, "result8");

        // Start while busy is acknowledged and ignored.
        push_run(64);
        s0 = start_cnt;
        wr(32'h0, 32'd1, "start_run2");
        wait_starts(s0 + 3, 200, "run2_three_starts");
        wr(32'h0, 32'd1, "start_while_busy");
        wait_idle(1500, "run2");
        check("run2_starts", 32'(start_cnt - s0), 32'd64);
        check("run2_idx_left", 32'(idx_q.size()), 32'd0);
        rd(32'h004, 32'h0040_0002, "run2_status");

        // Abort while waiting on pixel 5; late dp_done_i must be ignored.
        push_run(6);
        s0 = start_cnt;
        a0 = abort_cnt;
        wr(32'h0, 32'd1, "start_run3");
        wait_starts(s0 + 6, 200, "run3_six_starts");
        repeat (3) @(negedge clk_i);
        wr(32'h0, 32'd2, "abort_run3");
        repeat (2) @(negedge clk_i);
        check("run3_abort_pulse", 32'(abort_cnt - a0), 32'd1);
        repeat (20) @(negedge clk_i);
        rd(32'h004, 32'h0005_0000, "run3_status");
        check("run3_starts", 32'(start_cnt - s0), 32'd6);
        check("run3_idx_left", 32'(idx_q.size()), 32'd0);
        rd(32'h1FC, 32'd91, "run3_result63_kept");

        // Datapath never answers: timeout.
        dp_mode = 1;
        idx_q.push_back(32'd0);
        s0 = start_cnt;
        a0 = abort_cnt;
        wr(32'h0, 32'd1, "start_run4");
        wait_idle(1000, "run4");
        check("run4_starts", 32'(start_cnt - s0), 32'd1);
        check("run4_abort_pulse", 32'(abort_cnt - a0), 32'd1);
        check("run4_timeout_cycles", 32'(abort_cyc - start_cyc), 32'd1025);
        rd(32'h004, 32'h0000_0004, "run4_status");

        // Asynchronous reset mid-run: straight to idle, no abort pulse.
        dp_mode = 1;
        idx_q.push_back(32'd0);
        s0 = start_cnt;
        a0 = abort_cnt;
        wr(32'h0, 32'd1, "start_run5");
        wait_starts(s0 + 1, 50, "run5_start");
        repeat (3) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("run5_rst_abort",    {31'd0, dp_abort_o}, 32'd0);
        check("run5_rst_start",    {31'd0, dp_start_o}, 32'd0);
        check("run5_rst_data",     data_o,              32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("run5_no_abort", 32'(abort_cnt - a0), 32'd0);
        rd(32'h004, 32'h0000_0000, "run5_status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
